// File: rtl/uart_dbg_bridge_if.sv
// Debug memory bus between the UART bridge (master) and the SoC debug port (slave).
// Request is level-held on dbg_mem_op; completion is a one-clock dbg_ready strobe.
interface uart_dbg_bridge_if;
    logic        dbg_mem_op;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;
    logic [31:0] dbg_di;
    logic        dbg_ready;

    modport master (
        output dbg_mem_op, dbg_wren, dbg_adr, dbg_do,
        input  dbg_di, dbg_ready
    );

    modport slave (
        input  dbg_mem_op, dbg_wren, dbg_adr, dbg_do,
        output dbg_di, dbg_ready
    );
endinterface

// File: rtl/uart_dbg_bridge.sv
// UART (8N1) command bridge mastering the SoC debug memory port and CPU reset hold.
// Latency: bus request 1 clk after last arg byte; reply start bit 1 clk after entering RESP.
// Backpressure: bus waits for dbg_ready up to BUS_TIMEOUT clks; host bytes arriving in BUS/RESP are dropped.
module uart_dbg_bridge #(
    parameter int CLK_HZ      = 12000000,
    parameter int BAUD        = 115200,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              rx,
    output logic              tx,
    output logic              cpu_n_reset,
    uart_dbg_bridge_if.master dbg
);
    localparam int CPB      = CLK_HZ / BAUD;
    localparam int HALF     = CPB / 2;
    localparam int IB_LIMIT = 160 * CPB;
    localparam int BW       = $clog2(CPB + 1);
    localparam int IBW      = $clog2(IB_LIMIT + 1);
    localparam int TW       = $clog2(BUS_TIMEOUT + 1);

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_H = 8'h48;
    localparam logic [7:0] CMD_G = 8'h47;
    localparam logic [7:0] RSP_K = 8'h4B;
    localparam logic [7:0] RSP_Q = 8'h3F;
    localparam logic [7:0] RSP_E = 8'h45;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_e;
    typedef enum logic [1:0] {ST_IDLE, ST_ARGS, ST_BUS, ST_RESP} st_e;

    rx_st_e        rx_st_q, rx_st_d;
    logic [2:0]    rx_sync_q, rx_sync_d;
    logic [BW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          rx_vld_q, rx_vld_d;
    logic          rx_in;

    logic          tx_q, tx_d;
    logic          tx_busy_q, tx_busy_d;
    logic [BW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [8:0]    tx_sh_q, tx_sh_d;
    logic          tx_load;
    logic          tx_rdy;

    st_e            st_q, st_d;
    logic           is_wr_q, is_wr_d;
    logic [2:0]     arg_cnt_q, arg_cnt_d;
    logic [63:0]    arg_q, arg_d;
    logic [IBW-1:0] ib_q, ib_d;
    logic [TW-1:0]  tout_q, tout_d;
    logic           mem_op_q, mem_op_d;
    logic [3:0]     wren_q, wren_d;
    logic [31:0]    adr_q, adr_d;
    logic [31:0]    do_q, do_d;
    logic [31:0]    resp_q, resp_d;
    logic [2:0]     resp_len_q, resp_len_d;
    logic           cpu_n_reset_q, cpu_n_reset_d;

    // bit 1 is the synchronized line, bit 2 its previous value for edge detection
    assign rx_in = rx_sync_q[1];

    always_comb begin
        rx_sync_d = {rx_sync_q[1:0], rx};
        rx_st_d   = rx_st_q;
        rx_cnt_d  = rx_cnt_q + 1'b1;
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        rx_vld_d  = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_sync_q[2] && !rx_in) rx_st_d = RX_START;
            end
            RX_START: if (rx_cnt_q == BW'(HALF - 1)) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_st_d  = rx_in ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == BW'(CPB - 1)) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_in, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 1'b1;
                if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == BW'(CPB - 1)) begin
                rx_st_d  = RX_IDLE;
                rx_vld_d = rx_in;
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    // a new byte may start on the same edge the previous stop bit ends
    assign tx_rdy = !tx_busy_q || (tx_cnt_q == BW'(CPB - 1) && tx_bit_q == 4'd9);

    always_comb begin
        tx_d      = tx_q;
        tx_busy_d = tx_busy_q;
        tx_cnt_d  = tx_cnt_q;
        tx_bit_d  = tx_bit_q;
        tx_sh_d   = tx_sh_q;
        if (tx_load) begin
            tx_d      = 1'b0;
            tx_busy_d = 1'b1;
            tx_cnt_d  = '0;
            tx_bit_d  = '0;
            tx_sh_d   = {1'b1, resp_q[7:0]};
        end else if (tx_busy_q) begin
            if (tx_cnt_q == BW'(CPB - 1)) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                    tx_d      = 1'b1;
                end else begin
                    tx_d     = tx_sh_q[0];
                    tx_sh_d  = {1'b1, tx_sh_q[8:1]};
                    tx_bit_d = tx_bit_q + 1'b1;
                end
            end else begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        st_d          = st_q;
        is_wr_d       = is_wr_q;
        arg_cnt_d     = arg_cnt_q;
        arg_d         = arg_q;
        ib_d          = ib_q;
        tout_d        = tout_q;
        mem_op_d      = mem_op_q;
        wren_d        = wren_q;
        adr_d         = adr_q;
        do_d          = do_q;
        resp_d        = resp_q;
        resp_len_d    = resp_len_q;
        cpu_n_reset_d = cpu_n_reset_q;
        tx_load       = 1'b0;
        case (st_q)
            ST_IDLE: if (rx_vld_q) begin
                arg_cnt_d  = '0;
                ib_d       = '0;
                is_wr_d    = (rx_sh_q == CMD_W);
                resp_len_d = 3'd1;
                st_d       = ST_RESP;
                case (rx_sh_q)
                    CMD_W, CMD_R: st_d = ST_ARGS;
                    CMD_H: begin cpu_n_reset_d = 1'b0; resp_d = {24'h0, RSP_K}; end
                    CMD_G: begin cpu_n_reset_d = 1'b1; resp_d = {24'h0, RSP_K}; end
                    default: resp_d = {24'h0, RSP_Q};
                endcase
            end
            ST_ARGS: if (rx_vld_q) begin
                ib_d = '0;
                arg_d[{arg_cnt_q, 3'b000} +: 8] = rx_sh_q;
                arg_cnt_d = arg_cnt_q + 1'b1;
                if (arg_cnt_q == (is_wr_q ? 3'd7 : 3'd3)) begin
                    st_d     = ST_BUS;
                    tout_d   = '0;
                    mem_op_d = 1'b1;
                    adr_d    = arg_d[31:0];
                    wren_d   = is_wr_q ? 4'hF : 4'h0;
                    if (is_wr_q) do_d = arg_d[63:32];
                end
            end else if (ib_q == IBW'(IB_LIMIT - 1)) begin
                st_d = ST_IDLE;
            end else begin
                ib_d = ib_q + 1'b1;
            end
            ST_BUS: begin
                // ready wins over a timeout expiring in the same cycle
                if (dbg.dbg_ready) begin
                    mem_op_d = 1'b0;
                    wren_d   = 4'h0;
                    st_d     = ST_RESP;
                    if (is_wr_q) begin
                        resp_d     = {24'h0, RSP_K};
                        resp_len_d = 3'd1;
                    end else begin
                        resp_d     = dbg.dbg_di;
                        resp_len_d = 3'd4;
                    end
                end else if (tout_q == TW'(BUS_TIMEOUT - 1)) begin
                    mem_op_d   = 1'b0;
                    wren_d     = 4'h0;
                    resp_d     = {24'h0, RSP_E};
                    resp_len_d = 3'd1;
                    st_d       = ST_RESP;
                end else begin
                    tout_d = tout_q + 1'b1;
                end
            end
            ST_RESP: if (resp_len_q == 3'd0) begin
                st_d = ST_IDLE;
            end else if (tx_rdy) begin
                tx_load    = 1'b1;
                resp_d     = {8'h00, resp_q[31:8]};
                resp_len_d = resp_len_q - 1'b1;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rx_st_q       <= RX_IDLE;
            rx_sync_q     <= 3'b111;
            rx_cnt_q      <= '0;
            rx_bit_q      <= '0;
            rx_sh_q       <= '0;
            rx_vld_q      <= 1'b0;
            tx_q          <= 1'b1;
            tx_busy_q     <= 1'b0;
            tx_cnt_q      <= '0;
            tx_bit_q      <= '0;
            tx_sh_q       <= '1;
            st_q          <= ST_IDLE;
            is_wr_q       <= 1'b0;
            arg_cnt_q     <= '0;
            arg_q         <= '0;
            ib_q          <= '0;
            tout_q        <= '0;
            mem_op_q      <= 1'b0;
            wren_q        <= 4'h0;
            adr_q         <= '0;
            do_q          <= '0;
            resp_q        <= '0;
            resp_len_q    <= '0;
            cpu_n_reset_q <= 1'b1;
        end else begin
            rx_st_q       <= rx_st_d;
            rx_sync_q     <= rx_sync_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_bit_q      <= rx_bit_d;
            rx_sh_q       <= rx_sh_d;
            rx_vld_q      <= rx_vld_d;
            tx_q          <= tx_d;
            tx_busy_q     <= tx_busy_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_bit_q      <= tx_bit_d;
            tx_sh_q       <= tx_sh_d;
            st_q          <= st_d;
            is_wr_q       <= is_wr_d;
            arg_cnt_q     <= arg_cnt_d;
            arg_q         <= arg_d;
            ib_q          <= ib_d;
            tout_q        <= tout_d;
            mem_op_q      <= mem_op_d;
            wren_q        <= wren_d;
            adr_q         <= adr_d;
            do_q          <= do_d;
            resp_q        <= resp_d;
            resp_len_q    <= resp_len_d;
            cpu_n_reset_q <= cpu_n_reset_d;
        end
    end

    assign tx             = tx_q;
    assign cpu_n_reset    = cpu_n_reset_q;
    assign dbg.dbg_mem_op = mem_op_q;
    assign dbg.dbg_wren   = wren_q;
    assign dbg.dbg_adr    = adr_q;
    assign dbg.dbg_do     = do_q;
endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Bench for uart_dbg_bridge: host UART driver, reply decoder, debug-bus responder,
// directed command table, random commands against a command-level model, and corner sequences.
module tb_uart_dbg_bridge;
    localparam int CLK_HZ      = 12000000;
    localparam int BAUD        = 1000000;
    localparam int BUS_TIMEOUT = 255;
    localparam int CPB         = CLK_HZ / BAUD;

    logic clk = 1'b0;
    logic n_reset;
    logic rx;
    logic tx;
    logic cpu_n_reset;

    uart_dbg_bridge_if dbg_if ();

    uart_dbg_bridge #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .BUS_TIMEOUT(BUS_TIMEOUT)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .rx         (rx),
        .tx         (tx),
        .cpu_n_reset(cpu_n_reset),
        .dbg        (dbg_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] adr;
        logic [31:0] dat;      // write data, or read data the bench returns
        int          rdy_dly;  // bus cycles before dbg_ready; -1 = never
        logic        exp_bus;
        logic [3:0]  exp_wren;
        int          exp_nrep;
        logic [31:0] exp_rep;  // reply bytes, first byte in [7:0]
        logic        exp_cpu;
    } vec_t;

    int n_pass = 0;
    int n_tot  = 0;
    int mon_err = 0;
    logic [7:0] rep_q[$];
    logic       mon_cpu_q[$];
    logic       cpu_track;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Decodes every frame the DUT transmits into rep_q
    initial begin : tx_mon
        logic [7:0] b;
        logic ok;
        forever begin
            @(negedge clk);
            if (n_reset === 1'b1 && tx === 1'b0) begin
                mon_cpu_q.push_back(cpu_n_reset);
                repeat (CPB / 2) @(negedge clk);
                ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                ok = ok && (tx === 1'b1);
                if (ok) rep_q.push_back(b);
                else mon_err++;
            end
        end
    end

    task automatic uart_send(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (!stop_bit) repeat (CPB) @(negedge clk);
    endtask

    task automatic send_cmd(input vec_t v, input int bad_pos);
        logic [63:0] args;
        int n;
        args = {v.dat, v.adr};
        n = (v.cmd == 8'h57) ? 8 : (v.cmd == 8'h52) ? 4 : 0;
        uart_send(v.cmd, 1'b1);
        for (int i = 0; i < n; i++) begin
            if (i == bad_pos) uart_send(8'hEE, 1'b0);
            uart_send(args[8*i +: 8], 1'b1);
        end
    endtask

    task automatic bus_resp(input vec_t v);
        logic seen;
        logic stable;
        int held;
        int exp_held;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (dbg_if.dbg_mem_op === 1'b1) seen = 1'b1;
        end
        chk("bus_request_seen", {31'd0, seen}, 32'd1);
        if (!seen) return;
        chk("bus_adr", dbg_if.dbg_adr, v.adr);
        chk("bus_wren", {28'd0, dbg_if.dbg_wren}, {28'd0, v.exp_wren});
        if (v.cmd == 8'h57) chk("bus_do", dbg_if.dbg_do, v.dat);
        held = 0;
        stable = 1'b1;
        while (dbg_if.dbg_mem_op === 1'b1 && held < 400) begin
            if (dbg_if.dbg_adr !== v.adr || dbg_if.dbg_wren !== v.exp_wren) stable = 1'b0;
            if (held == v.rdy_dly) begin
                dbg_if.dbg_ready = 1'b1;
                dbg_if.dbg_di    = v.dat;
            end
            @(negedge clk);
            dbg_if.dbg_ready = 1'b0;
            dbg_if.dbg_di    = $urandom;
            held++;
        end
        // a late strobe arrives after the request has dropped and must be ignored
        if (v.rdy_dly >= held) begin
            dbg_if.dbg_ready = 1'b1;
            @(negedge clk);
            dbg_if.dbg_ready = 1'b0;
        end
        exp_held = (v.rdy_dly >= 0 && v.rdy_dly < BUS_TIMEOUT) ? v.rdy_dly + 1 : BUS_TIMEOUT;
        chk("bus_held_clocks", held, exp_held);
        chk("bus_stable", {31'd0, stable}, 32'd1);
        chk("wren_after_op", {28'd0, dbg_if.dbg_wren}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int bad_pos);
        rep_q.delete();
        mon_cpu_q.delete();
        fork
            send_cmd(v, bad_pos);
            if (v.exp_bus) bus_resp(v);
        join
        for (int i = 0; i < 300 * CPB && rep_q.size() < v.exp_nrep; i++) @(negedge clk);
        repeat (15 * CPB) @(negedge clk);
        chk("reply_count", rep_q.size(), v.exp_nrep);
        for (int i = 0; i < v.exp_nrep && i < rep_q.size(); i++)
            chk("reply_byte", {24'd0, rep_q[i]}, {24'd0, v.exp_rep[8*i +: 8]});
        chk("cpu_n_reset", {31'd0, cpu_n_reset}, {31'd0, v.exp_cpu});
        if (mon_cpu_q.size() > 0)
            chk("cpu_n_reset_at_reply", {31'd0, mon_cpu_q[0]}, {31'd0, v.exp_cpu});
        if (v.exp_bus) chk("adr_retained", dbg_if.dbg_adr, v.adr);
        if (!v.exp_bus) chk("no_bus_op", {31'd0, dbg_if.dbg_mem_op}, 32'd0);
    endtask

    // Command-level behaviour: what the host should see for one command
    function automatic vec_t model(input logic [7:0] cmd, input logic [31:0] adr,
                                   input logic [31:0] dat, input int dly, input logic cpu_now);
        vec_t r;
        logic ok;
        ok = (dly >= 0 && dly < BUS_TIMEOUT);
        r.cmd = cmd; r.adr = adr; r.dat = dat; r.rdy_dly = dly;
        r.exp_bus = 1'b0; r.exp_wren = 4'h0; r.exp_nrep = 1; r.exp_cpu = cpu_now;
        case (cmd)
            8'h57: begin r.exp_bus = 1'b1; r.exp_wren = 4'hF; r.exp_rep = ok ? 32'h4B : 32'h45; end
            8'h52: begin
                r.exp_bus = 1'b1;
                r.exp_rep = ok ? dat : 32'h45;
                r.exp_nrep = ok ? 4 : 1;
            end
            8'h48: begin r.exp_cpu = 1'b0; r.exp_rep = 32'h4B; end
            8'h47: begin r.exp_cpu = 1'b1; r.exp_rep = 32'h4B; end
            default: r.exp_rep = 32'h3F;
        endcase
        return r;
    endfunction

    initial begin
        vec_t tbl[10];
        vec_t v;
        logic [7:0] c;
        int k;

        tbl[0] = '{8'h57, 32'h00010010, 32'h00000011,   5, 1'b1, 4'hF, 1, 32'h0000004B, 1'b1};
        tbl[1] = '{8'h52, 32'h00010014, 32'h00000088,   3, 1'b1, 4'h0, 4, 32'h00000088, 1'b1};
        tbl[2] = '{8'h48, 32'h0,        32'h0,         -1, 1'b0, 4'h0, 1, 32'h0000004B, 1'b0};
        tbl[3] = '{8'h57, 32'h80000004, 32'hCAFEF00D,   0, 1'b1, 4'hF, 1, 32'h0000004B, 1'b0};
        tbl[4] = '{8'h47, 32'h0,        32'h0,         -1, 1'b0, 4'h0, 1, 32'h0000004B, 1'b1};
        tbl[5] = '{8'h00, 32'h0,        32'h0,         -1, 1'b0, 4'h0, 1, 32'h0000003F, 1'b1};
        tbl[6] = '{8'h52, 32'hDEADBEE0, 32'h12345678,  -1, 1'b1, 4'h0, 1, 32'h00000045, 1'b1};
        tbl[7] = '{8'h52, 32'h00000100, 32'hA5C30F71, 254, 1'b1, 4'h0, 4, 32'hA5C30F71, 1'b1};
        tbl[8] = '{8'h52, 32'h00000104, 32'h11223344, 255, 1'b1, 4'h0, 1, 32'h00000045, 1'b1};
        tbl[9] = '{8'h57, 32'h00000200, 32'h55AA55AA,  -1, 1'b1, 4'hF, 1, 32'h00000045, 1'b1};

        n_reset = 1'b0;
        rx = 1'b1;
        dbg_if.dbg_ready = 1'b0;
        dbg_if.dbg_di = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_mem_op", {31'd0, dbg_if.dbg_mem_op}, 32'd0);
        chk("rst_wren", {28'd0, dbg_if.dbg_wren}, 32'd0);
        chk("rst_adr", dbg_if.dbg_adr, 32'd0);
        chk("rst_do", dbg_if.dbg_do, 32'd0);
        chk("rst_cpu_n_reset", {31'd0, cpu_n_reset}, 32'd1);
        n_reset = 1'b1;
        repeat (5) @(negedge clk);

        foreach (tbl[i]) run_vec(tbl[i], -1);
        cpu_track = 1'b1;

        // 3-clock glitch must not look like a start bit
        rep_q.delete();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30 * CPB) @(negedge clk);
        chk("glitch_no_reply", rep_q.size(), 0);

        // truncated write aborts silently, then a fresh command works
        uart_send(8'h57, 1'b1);
        uart_send(8'h10, 1'b1);
        uart_send(8'h00, 1'b1);
        repeat (160 * CPB + 200) @(negedge clk);
        chk("abort_no_reply", rep_q.size(), 0);
        chk("abort_no_bus", {31'd0, dbg_if.dbg_mem_op}, 32'd0);
        v = model(8'h47, 32'h0, 32'h0, -1, cpu_track);
        run_vec(v, -1);
        cpu_track = v.exp_cpu;

        // framing-error byte inside the argument field is not counted
        v = model(8'h52, 32'h04030201, 32'h77665544, 2, cpu_track);
        run_vec(v, 2);

        for (int n = 0; n < 8; n++) begin
            k = $urandom_range(0, 4);
            case (k)
                0: c = 8'h57;
                1: c = 8'h52;
                2: c = 8'h48;
                3: c = 8'h47;
                default: begin
                    c = 8'($urandom_range(0, 255));
                    while (c == 8'h57 || c == 8'h52 || c == 8'h48 || c == 8'h47) c = c + 8'd1;
                end
            endcase
            v = model(c, $urandom, $urandom,
                      ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 30)), cpu_track);
            run_vec(v, -1);
            cpu_track = v.exp_cpu;
        end

        // reset in the middle of a bus operation
        rep_q.delete();
        uart_send(8'h52, 1'b1);
        for (int i = 0; i < 4; i++) uart_send(8'h3C, 1'b1);
        repeat (3) @(negedge clk);
        chk("rst_mid_bus_active", {31'd0, dbg_if.dbg_mem_op}, 32'd1);
        #2 n_reset = 1'b0;
        #1;
        chk("rst_mid_mem_op", {31'd0, dbg_if.dbg_mem_op}, 32'd0);
        chk("rst_mid_tx", {31'd0, tx}, 32'd1);
        chk("rst_mid_adr", dbg_if.dbg_adr, 32'd0);
        chk("rst_mid_cpu", {31'd0, cpu_n_reset}, 32'd1);
        repeat (4) @(negedge clk);
        n_reset = 1'b1;
        repeat (40 * CPB) @(negedge clk);
        chk("rst_no_reply", rep_q.size(), 0);
        chk("rst_no_bus", {31'd0, dbg_if.dbg_mem_op}, 32'd0);

        chk("tx_frame_errors", mon_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/uart_dbg_bridge.md
# uart_dbg_bridge

Host-side debug bridge for the picorv32 SoC: receives command frames from a host over an 8N1 UART and masters the SoC debug memory port (dbg_mem_op / dbg_wren / dbg_adr / dbg_do), returning read data and acknowledgements over UART TX. It also drives the CPU reset hold. It sits between the board's host UART pins and the SoC debug port, and replaces bench-forced debug signals with real traffic.

## Interface
- CLK_HZ, 12000000, system clock frequency in Hz
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, must be ≥ 4)
- BUS_TIMEOUT, 255, max clocks to wait for dbg_ready before error
- clk  in  1  system clock, all logic rising-edge
- n_reset  in  1  reset, asynchronous, active-low
- rx  in  1  host UART receive, idle high, asynchronous to clk
- tx  out  1  host UART transmit, idle high
- dbg_mem_op  out  1  debug bus request, held until dbg_ready
- dbg_wren  out  4  byte write enables; 4'h0 = read
- dbg_adr  out  32  debug bus byte address
- dbg_do  out  32  write data
- dbg_di  in  32  read data, valid when dbg_ready=1
- dbg_ready  in  1  one-cycle completion strobe from SoC
- cpu_n_reset  out  1  CPU reset hold, active-low

## Operation
- RX: 2-FF synchronizer; falling edge starts bit timer; start bit re-sampled at CLKS_PER_BIT/2, high → false start, return to idle; data sampled mid-bit, LSB first; stop bit sampled mid-bit, low → framing error, byte dropped.
- TX: 8N1, LSB first; a byte is loaded only when TX idle; tx high between bytes.
- Commands (first byte), multi-byte fields LSB first:
  - 0x57 'W' + 4 addr + 4 data → bus write, wren=4'hF → reply 0x4B 'K'
  - 0x52 'R' + 4 addr → bus read, wren=4'h0 → reply 4 bytes dbg_di, LSB first
  - 0x48 'H' → cpu_n_reset=0 → reply 'K'
  - 0x47 'G' → cpu_n_reset=1 → reply 'K'
  - any other → reply 0x3F '?'
- FSM states: IDLE → ARGS (count 4 or 8 bytes) → BUS → RESP → IDLE; H/G/unknown go IDLE → RESP directly.
- BUS: dbg_mem_op=1 with adr/do/wren stable until dbg_ready=1; if BUS_TIMEOUT clocks elapse without dbg_ready, drop request and reply 0x45 'E' (single byte, also for reads).
- Bytes received while in BUS or RESP are discarded.
- Inter-byte timeout: in ARGS, 16·10·CLKS_PER_BIT clocks with no new byte → abort to IDLE, no reply.
- Framing-error byte in ARGS does not count toward the argument total.

## Timing
- Reset values: tx=1, dbg_mem_op=0, dbg_wren=0, dbg_adr=0, dbg_do=0, cpu_n_reset=1, FSM=IDLE, RX/TX idle.
- Reset assertion mid-frame or mid-bus-op: all outputs return to reset values immediately (async); no reply is sent after reset release.
- Byte-valid pulse from RX: one clock, the cycle after the stop-bit sample.
- Bus request: dbg_mem_op rises the clock after the final argument byte-valid.
- dbg_ready sampled high on cycle N → dbg_mem_op=0 and dbg_wren=0 on N+1; read data captured on N.
- dbg_ready coincident with the timeout expiry cycle → treated as success.
- dbg_ready while dbg_mem_op=0 → ignored.
- TX start bit begins the clock after entering RESP; multi-byte replies back-to-back, no extra idle bits.
- H/G: cpu_n_reset changes the clock after command byte-valid, before the 'K' start bit.
- dbg_adr/dbg_do keep last values after a transaction.

## Test plan
- CLK_HZ=12000000, BAUD=1000000: host sends 57 10 00 01 00 11 00 00 00 → one request adr=0x00010010, do=0x00000011, wren=F, held until bench pulses dbg_ready 5 clocks later; tx returns 0x4B.
- Send 52 14 00 01 00, bench returns dbg_di=0x00000088 with ready → wren=0 during op; tx returns 88 00 00 00.
- Read with dbg_ready never asserted → dbg_mem_op drops after exactly 255 clocks; tx returns 0x45.
- Send 0x48 then 0x47 → cpu_n_reset 1→0→1, two 0x4B replies; send 0x00 → 0x3F.
- 3-clock low glitch on rx → no byte; 'W' then 2 addr bytes then silence → abort, no reply, next 'G' handled normally.
- Pull n_reset low during BUS state → dbg_mem_op=0 same cycle, tx=1, no reply after release.
